mem_wb_flush_buffer: RTL and testbench

MEM_WB_FLUSH_BUFFER -- requirements
Module: mem_wb_flush_buffer

---
 rtl/mem_wb_flush_buffer_pkg.sv | 42 ++++
 rtl/mem_wb_flush_buffer_if.sv | 23 ++
 rtl/mem_wb_flush_buffer.sv | 123 ++++++++++++
 tb/tb_mem_wb_flush_buffer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_flush_buffer_pkg.sv
// Shared pipeline types for the memory-access to register-write boundary.
// Holds the op payload layout, active-list index width and the flush-range check
// used by every stage that drops ops on a selective recovery.
package mem_wb_flush_buffer_pkg;

    localparam int ACTIVE_LIST_ENTRY_NUM   = 64;
    localparam int ACTIVE_LIST_INDEX_WIDTH = $clog2(ACTIVE_LIST_ENTRY_NUM);
    localparam int MEM_WB_BUFFER_ENTRY_NUM = 2;

    typedef logic [ACTIVE_LIST_INDEX_WIDTH-1:0] ActiveListIndexPath;
    typedef logic [5:0]                         PRegNumPath;

    typedef struct packed {
        ActiveListIndexPath activeListPtr;
        PRegNumPath         phyDstReg;
        logic               regWrite;
        logic [31:0]        dataOut;
    } MemoryRegisterWriteStageRegPath;

    // Half-open range [head, tail) on the circular active list; head==tail is empty.
    function automatic logic in_flush_range(
        input ActiveListIndexPath p,
        input ActiveListIndexPath head,
        input ActiveListIndexPath tail
    );
        if (head < tail)      return (p >= head) && (p < tail);
        else if (head > tail) return (p >= head) || (p < tail);
        else                  return 1'b0;
    endfunction

    // An op is dropped only while recover is high, either wholesale or by range.
    function automatic logic is_op_flushed(
        input logic               recover,
        input logic               flush_all,
        input ActiveListIndexPath p,
        input ActiveListIndexPath head,
        input ActiveListIndexPath tail
    );
        return recover && (flush_all || in_flush_range(p, head, tail));
    endfunction

endpackage

// File: rtl/mem_wb_flush_buffer_if.sv
// Valid/ready handshake bundle between the memory access stage, the
// flush buffer and the memory register write stage.
// master = environment side, slave = the buffer itself.
interface mem_wb_flush_buffer_if;
    import mem_wb_flush_buffer_pkg::*;

    logic                           inValid;
    logic                           inReady;
    MemoryRegisterWriteStageRegPath inPayload;
    logic                           outValid;
    logic                           outReady;
    MemoryRegisterWriteStageRegPath outPayload;

    modport master (
        output inValid, inPayload, outReady,
        input  inReady, outValid, outPayload
    );

    modport slave (
        input  inValid, inPayload, outReady,
        output inReady, outValid, outPayload
    );
endinterface

// File: rtl/mem_wb_flush_buffer.sv
// Circular op buffer between memory access and register write that drops ops hit by selective flush.
// Latency: 1 cycle minimum from enqueue to outValid; no same-cycle pass-through.
// Backpressure: inReady low when full, stalled or clearing; outValid held off while stalled, clearing or head flushed.
module mem_wb_flush_buffer
    import mem_wb_flush_buffer_pkg::*;
#(
    parameter int ENTRY_NUM       = MEM_WB_BUFFER_ENTRY_NUM,
    parameter int FLUSH_CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic                        clear,
    mem_wb_flush_buffer_if.slave        bus,
    input  logic                        recover,
    input  logic                        flushAllInsns,
    input  ActiveListIndexPath          flushHeadPtr,
    input  ActiveListIndexPath          flushTailPtr,
    output logic [$clog2(ENTRY_NUM):0]  count,
    output logic [FLUSH_CNT_WIDTH-1:0]  flushedCnt
);

    localparam int IDX_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = IDX_W + 1;
    localparam int SUM_W = FLUSH_CNT_WIDTH + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ENTRY_NUM);

    logic [ENTRY_NUM-1:0]           r_valid;
    MemoryRegisterWriteStageRegPath r_payload [ENTRY_NUM];
    logic [IDX_W-1:0]               r_head;
    logic [IDX_W-1:0]               r_tail;
    logic [CNT_W-1:0]               r_count;
    logic [FLUSH_CNT_WIDTH-1:0]     r_flushed_cnt;

    logic [ENTRY_NUM-1:0]           w_slot_flush;
    logic                           w_head_valid;
    logic                           w_head_flush;
    logic                           w_in_flush;
    logic                           w_in_ready;
    logic                           w_out_valid;
    logic                           w_enq;
    logic                           w_deq;
    logic                           w_pop;
    logic [SUM_W-1:0]               w_drop_num;
    logic [SUM_W-1:0]               w_flushed_sum;

    // Per-slot flush match against the current recovery range.
    always_comb begin
        w_slot_flush = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            w_slot_flush[i] = is_op_flushed(recover, flushAllInsns, r_payload[i].activeListPtr,
                                            flushHeadPtr, flushTailPtr);
        end
    end

    assign w_head_valid = r_valid[r_head];
    assign w_head_flush = w_slot_flush[r_head];
    assign w_in_flush   = is_op_flushed(recover, flushAllInsns, bus.inPayload.activeListPtr,
                                        flushHeadPtr, flushTailPtr);

    assign w_in_ready  = !rst && !stall && !clear && (r_count < FULL_CNT);
    assign w_out_valid = !rst && w_head_valid && (r_count != '0) && !stall && !clear && !w_head_flush;

    assign w_enq = bus.inValid && w_in_ready && !w_in_flush;
    assign w_deq = w_out_valid && bus.outReady;
    // A head left invalid by an earlier flush is retired silently, one per cycle.
    assign w_pop = !rst && !stall && !clear && (r_count != '0) && !w_head_valid;

    // Number of live ops dropped this cycle (stored slots plus the op offered at the input).
    always_comb begin
        w_drop_num = '0;
        if (!clear) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                w_drop_num = w_drop_num + SUM_W'(r_valid[i] && w_slot_flush[i]);
            end
            w_drop_num = w_drop_num + SUM_W'(bus.inValid && w_in_ready && w_in_flush);
        end
        w_flushed_sum = {1'b0, r_flushed_cnt} + w_drop_num;
    end

    // Control state: valid bits, pointers, occupancy and the saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_flushed_cnt <= '0;
        end else if (clear) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_valid <= r_valid & ~w_slot_flush;
            if (w_deq || w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + IDX_W'(1);
            end
            if (w_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + IDX_W'(1);
            end
            r_count       <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq || w_pop);
            r_flushed_cnt <= w_flushed_sum[FLUSH_CNT_WIDTH] ? '1
                                                              : w_flushed_sum[FLUSH_CNT_WIDTH-1:0];
        end
    end

    // Payload storage is written only on enqueue and needs no reset.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_payload[r_tail] <= bus.inPayload;
        end
    end

    assign bus.inReady    = w_in_ready;
    assign bus.outValid   = w_out_valid;
    assign bus.outPayload = r_payload[r_head];
    assign count          = r_count;
    assign flushedCnt     = r_flushed_cnt;

endmodule

// File: tb/tb_mem_wb_flush_buffer.sv
// Self-checking bench for mem_wb_flush_buffer: scoreboard of ops expected downstream,
// popped and compared whenever the buffer hands an op over, plus per-scenario checks.
module tb_mem_wb_flush_buffer;
    import mem_wb_flush_buffer_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               stall;
    logic               clear;
    logic               recover;
    logic               flushAllInsns;
    ActiveListIndexPath flushHeadPtr;
    ActiveListIndexPath flushTailPtr;
    logic [1:0]         count;
    logic [15:0]        flushedCnt;

    mem_wb_flush_buffer_if bus();

    mem_wb_flush_buffer #(
        .ENTRY_NUM      (2),
        .FLUSH_CNT_WIDTH(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .clear        (clear),
        .bus          (bus),
        .recover      (recover),
        .flushAllInsns(flushAllInsns),
        .flushHeadPtr (flushHeadPtr),
        .flushTailPtr (flushTailPtr),
        .count        (count),
        .flushedCnt   (flushedCnt)
    );

    always #5 clk = ~clk;

    int                             n_cmp = 0;
    int                             n_err = 0;
    MemoryRegisterWriteStageRegPath exp_q[$];
    bit                             drv_expect;
    bit                             last_acc;
    bit                             last_deq;
    logic [15:0]                    exp_flushed;

    function automatic MemoryRegisterWriteStageRegPath mk(input ActiveListIndexPath ptr,
                                                          input logic [31:0] data);
        MemoryRegisterWriteStageRegPath p;
        p.activeListPtr = ptr;
        p.phyDstReg     = ptr ^ 6'h2a;
        p.regWrite      = 1'b1;
        p.dataOut       = data;
        return p;
    endfunction

    // One clock: sample handshakes before the edge, score outputs, then advance past the edge.
    task automatic cycle();
        MemoryRegisterWriteStageRegPath exp;
        @(negedge clk);
        last_acc = bus.inValid && bus.inReady;
        last_deq = bus.outValid && bus.outReady;
        if (last_deq) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL out_unexpected: got ptr=%0d data=%h, required no output",
                         bus.outPayload.activeListPtr, bus.outPayload.dataOut);
            end else begin
                exp = exp_q.pop_front();
                if (bus.outPayload !== exp) begin
                    n_err++;
                    $display("FAIL out_payload: got %h, required %h", bus.outPayload, exp);
                end
            end
        end
        if (last_acc && drv_expect) exp_q.push_back(bus.inPayload);
        @(posedge clk);
        #1;
        if (last_acc) bus.inValid = 1'b0;
    endtask

    task automatic send(input ActiveListIndexPath ptr, input logic [31:0] data,
                        input bit expect_out, input bit rand_ready);
        bus.inValid   = 1'b1;
        bus.inPayload = mk(ptr, data);
        drv_expect    = expect_out;
        for (int k = 0; k < 50; k++) begin
            if (rand_ready) bus.outReady = 1'($urandom_range(0, 1));
            cycle();
            if (last_acc) return;
        end
        n_cmp++; n_err++;
        $display("FAIL send_timeout: ptr=%0d not accepted, required acceptance within 50 cycles", ptr);
        bus.inValid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        bus.outReady = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (exp_q.size() == 0 && count == 2'd0) begin
                done = 1'b1;
                break;
            end
            cycle();
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL drain_timeout: left=%0d count=%0d, required 0 and 0", exp_q.size(), count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; clear = 1'b0; recover = 1'b0; flushAllInsns = 1'b0;
        flushHeadPtr = '0; flushTailPtr = '0;
        bus.inValid = 1'b0; bus.outReady = 1'b0; bus.inPayload = mk(0, 0);
        drv_expect = 1'b0; exp_flushed = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (count !== 2'd0)   begin n_err++; $display("FAIL rst_count: got %0d, required 0", count); end
        n_cmp++; if (flushedCnt !== 16'd0) begin n_err++; $display("FAIL rst_flushed: got %0d, required 0", flushedCnt); end
        n_cmp++; if (bus.inReady !== 1'b0) begin n_err++; $display("FAIL rst_inready: got %b, required 0", bus.inReady); end
        n_cmp++; if (bus.outValid !== 1'b0) begin n_err++; $display("FAIL rst_outvalid: got %b, required 0", bus.outValid); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.inReady !== 1'b1) begin n_err++; $display("FAIL post_rst_inready: got %b, required 1", bus.inReady); end
    endtask

    task automatic test_fill_drain();
        bus.outReady = 1'b0;
        send(6'd1, 32'hA0A0_0001, 1'b1, 1'b0);
        send(6'd2, 32'hB0B0_0002, 1'b1, 1'b0);
        bus.inValid = 1'b1; bus.inPayload = mk(6'd3, 32'hC0C0_0003); drv_expect = 1'b1;
        #1;
        n_cmp++; if (bus.inReady !== 1'b0) begin n_err++; $display("FAIL full_inready: got %b, required 0", bus.inReady); end
        n_cmp++; if (count !== 2'd2) begin n_err++; $display("FAIL full_count: got %0d, required 2", count); end
        bus.outReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_cmp++;
            if (last_deq !== 1'b1) begin n_err++; $display("FAIL drain_cycle%0d: got deq=%b, required 1", k, last_deq); end
        end
        n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL drain_count: got %0d, required 0", count); end
        n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL drain_left: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_wrap_flush();
        bus.outReady = 1'b0;
        send(6'd62, 32'h0000_0062, 1'b0, 1'b0);
        send(6'd1,  32'h0000_0001, 1'b0, 1'b0);
        recover = 1'b1; flushHeadPtr = 6'd60; flushTailPtr = 6'd2; bus.outReady = 1'b1;
        #1;
        n_cmp++; if (bus.outValid !== 1'b0) begin n_err++; $display("FAIL wrap_outvalid_flush: got %b, required 0", bus.outValid); end
        cycle();
        recover = 1'b0;
        exp_flushed = exp_flushed + 16'd2;
        n_cmp++; if (flushedCnt !== exp_flushed) begin n_err++; $display("FAIL wrap_flushed: got %0d, required %0d", flushedCnt, exp_flushed); end
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (bus.outValid !== 1'b0) begin n_err++; $display("FAIL wrap_outvalid%0d: got %b, required 0", k, bus.outValid); end
            cycle();
        end
        n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL wrap_count: got %0d, required 0", count); end
    endtask

    task automatic test_partial_flush();
        bus.outReady = 1'b0;
        send(6'd5, 32'h0000_0005, 1'b1, 1'b0);
        send(6'd9, 32'h0000_0009, 1'b0, 1'b0);
        recover = 1'b1; flushHeadPtr = 6'd8; flushTailPtr = 6'd12;
        #1;
        n_cmp++; if (bus.outValid !== 1'b1) begin n_err++; $display("FAIL part_head_valid: got %b, required 1", bus.outValid); end
        cycle();
        recover = 1'b0;
        exp_flushed = exp_flushed + 16'd1;
        n_cmp++; if (flushedCnt !== exp_flushed) begin n_err++; $display("FAIL part_flushed: got %0d, required %0d", flushedCnt, exp_flushed); end
        n_cmp++; if (count !== 2'd2) begin n_err++; $display("FAIL part_count2: got %0d, required 2", count); end
        bus.outReady = 1'b1;
        cycle();
        n_cmp++; if (last_deq !== 1'b1) begin n_err++; $display("FAIL part_deliver: got deq=%b, required 1", last_deq); end
        n_cmp++; if (count !== 2'd1) begin n_err++; $display("FAIL part_count1: got %0d, required 1", count); end
        #1;
        n_cmp++; if (bus.outValid !== 1'b0) begin n_err++; $display("FAIL part_dead_head: got %b, required 0", bus.outValid); end
        cycle();
        n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL part_count0: got %0d, required 0", count); end
    endtask

    task automatic test_simultaneous();
        bus.outReady = 1'b0;
        recover = 1'b1; flushHeadPtr = 6'd10; flushTailPtr = 6'd11;
        bus.inValid = 1'b1; bus.inPayload = mk(6'd10, 32'h0000_0010); drv_expect = 1'b0;
        #1;
        n_cmp++; if (bus.inReady !== 1'b1) begin n_err++; $display("FAIL simul_inready: got %b, required 1", bus.inReady); end
        cycle();
        recover = 1'b0; bus.inValid = 1'b0;
        exp_flushed = exp_flushed + 16'd1;
        #1;
        n_cmp++; if (flushedCnt !== exp_flushed) begin n_err++; $display("FAIL simul_flushed: got %0d, required %0d", flushedCnt, exp_flushed); end
        n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL simul_count: got %0d, required 0", count); end
        n_cmp++; if (bus.outValid !== 1'b0) begin n_err++; $display("FAIL simul_outvalid: got %b, required 0", bus.outValid); end
    endtask

    task automatic test_clear_stall();
        bus.outReady = 1'b0;
        send(6'd20, 32'h0000_0020, 1'b0, 1'b0);
        send(6'd21, 32'h0000_0021, 1'b0, 1'b0);
        stall = 1'b1; recover = 1'b1; flushHeadPtr = 6'd21; flushTailPtr = 6'd22; bus.outReady = 1'b1;
        #1;
        n_cmp++; if (bus.outValid !== 1'b0) begin n_err++; $display("FAIL stall_outvalid: got %b, required 0", bus.outValid); end
        n_cmp++; if (bus.inReady !== 1'b0) begin n_err++; $display("FAIL stall_inready: got %b, required 0", bus.inReady); end
        cycle();
        recover = 1'b0;
        exp_flushed = exp_flushed + 16'd1;
        n_cmp++; if (flushedCnt !== exp_flushed) begin n_err++; $display("FAIL stall_flushed: got %0d, required %0d", flushedCnt, exp_flushed); end
        n_cmp++; if (count !== 2'd2) begin n_err++; $display("FAIL stall_count: got %0d, required 2", count); end
        clear = 1'b1;
        cycle();
        clear = 1'b0; stall = 1'b0;
        #1;
        n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL clear_count: got %0d, required 0", count); end
        n_cmp++; if (bus.outValid !== 1'b0) begin n_err++; $display("FAIL clear_outvalid: got %b, required 0", bus.outValid); end
        n_cmp++; if (flushedCnt !== exp_flushed) begin n_err++; $display("FAIL clear_flushed: got %0d, required %0d", flushedCnt, exp_flushed); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            send(ActiveListIndexPath'(i + 30), $urandom, 1'b1, 1'b1);
        end
        drain();
        n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL b2b_count: got %0d, required 0", count); end
    endtask

    task automatic test_rst_mid();
        bus.outReady = 1'b0;
        send(6'd40, 32'h0000_0040, 1'b0, 1'b0);
        send(6'd41, 32'h0000_0041, 1'b0, 1'b0);
        n_cmp++; if (count !== 2'd2) begin n_err++; $display("FAIL rstmid_pre_count: got %0d, required 2", count); end
        rst = 1'b1; bus.outReady = 1'b1; recover = 1'b1; flushAllInsns = 1'b1;
        bus.inValid = 1'b1; bus.inPayload = mk(6'd42, 32'h0000_0042); drv_expect = 1'b0;
        #1;
        n_cmp++; if (bus.outValid !== 1'b0) begin n_err++; $display("FAIL rstmid_outvalid_during: got %b, required 0", bus.outValid); end
        cycle();
        rst = 1'b0; recover = 1'b0; flushAllInsns = 1'b0; bus.inValid = 1'b0; bus.outReady = 1'b0;
        exp_flushed = '0;
        #1;
        n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL rstmid_count: got %0d, required 0", count); end
        n_cmp++; if (bus.outValid !== 1'b0) begin n_err++; $display("FAIL rstmid_outvalid: got %b, required 0", bus.outValid); end
        n_cmp++; if (flushedCnt !== exp_flushed) begin n_err++; $display("FAIL rstmid_flushed: got %0d, required 0", flushedCnt); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap_flush();
        test_partial_flush();
        test_simultaneous();
        test_clear_stall();
        test_back_to_back();
        test_rst_mid();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL scoreboard_left: got %0d pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
